// File: rtl/aes_scan_pkg.sv
// Shared types and constants for the scan-side AES core scheduler.
package aes_scan_pkg;

  localparam int unsigned AES_BLK_W            = 128;
  localparam int unsigned DEFAULT_CORE_LATENCY = 11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester above ptr_i, with wrap.
module rr_arbiter
  import aes_scan_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o,
  output logic               valid_o
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        id_o        = cand;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/aes_core_sched.sv
// Shares one AES-128 core between NUM_REQ requesters, round-robin, one block at a time.
// Optional AES_CORE_SCHED_STATS_EN adds done_count/stall_cycles statistics outputs.
module aes_core_sched
  import aes_scan_pkg::*;
#(
  parameter int unsigned  NUM_REQ      = 4,
  parameter int unsigned  CORE_LATENCY = DEFAULT_CORE_LATENCY,
  localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_data,
  input  logic [AES_BLK_W-1:0]         key,
  output logic                         core_rst_n,
  output logic                         core_en,
  output logic                         core_start,
  output logic [AES_BLK_W-1:0]         core_plaintext,
  output logic [AES_BLK_W-1:0]         core_key,
  input  logic [AES_BLK_W-1:0]         core_cyphertext,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [AES_BLK_W-1:0]         resp_data,
  output logic [ID_W-1:0]              resp_id,
  output logic                         busy
`ifdef AES_CORE_SCHED_STATS_EN
  ,
  output logic [15:0]                  done_count,
  output logic [15:0]                  stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(CORE_LATENCY + 1);

  sched_state_t         state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d, id_q, id_d, gnt_id;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_vld;
  logic [AES_BLK_W-1:0] pt_q, pt_d, key_q, key_d, resp_data_q, resp_data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 accept, run_done, resp_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .id_o    (gnt_id),
    .valid_o (gnt_vld)
  );

  assign accept   = (state_q == IDLE) && gnt_vld;
  assign run_done = (state_q == RUN) && (cnt_q == CNT_W'(CORE_LATENCY));
  assign resp_hs  = resp_valid_q && resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_vld) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (run_done) state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    id_d         = id_q;
    pt_d         = pt_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    if (accept) begin
      ptr_d = gnt_id;
      id_d  = gnt_id;
      pt_d  = req_data[AES_BLK_W*gnt_id +: AES_BLK_W];
      key_d = key;
    end
    if (state_q == LOAD) begin
      cnt_d = CNT_W'(1);
    end else if ((state_q == RUN) && !run_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (run_done) begin
      resp_data_d  = core_cyphertext;
      resp_valid_d = 1'b1;
    end else if (resp_hs) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      pt_q         <= '0;
      key_q        <= '0;
      cnt_q        <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Core sees reset with enable already high in LOAD, then start held for the whole RUN.
  always_comb begin
    core_en    = 1'b0;
    core_rst_n = 1'b0;
    core_start = 1'b0;
    req_ready  = '0;
    unique case (state_q)
      IDLE: req_ready = reset ? '0 : gnt;
      LOAD: core_en = 1'b1;
      RUN: begin
        core_en    = 1'b1;
        core_rst_n = 1'b1;
        core_start = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_id        = id_q;
  assign busy           = (state_q != IDLE);

`ifdef AES_CORE_SCHED_STATS_EN
  logic [15:0] done_q, done_d, stall_q, stall_d;

  always_comb begin
    done_d  = done_q;
    stall_d = stall_q;
    if (resp_hs && (done_q != 16'hFFFF)) begin
      done_d = done_q + 16'd1;
    end
    if ((state_q == RESP) && !resp_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= '0;
      stall_q <= '0;
    end else begin
      done_q  <= done_d;
      stall_q <= stall_d;
    end
  end

  assign done_count   = done_q;
  assign stall_cycles = stall_q;
`endif

endmodule
